// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame shape and FSM state encoding.
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Dequeue handshake between the UART receiver (master) and its byte consumer (slave).
interface uart_receiver_if;
   import uart_pkg::*;

   logic                 io_deq_valid;
   logic                 io_deq_ready;
   logic [DATA_BITS-1:0] io_deq_bits;

   modport master (output io_deq_valid, output io_deq_bits, input io_deq_ready);
   modport slave  (input io_deq_valid, input io_deq_bits, output io_deq_ready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Small power-of-two receive FIFO. A pop frees a slot in the same cycle, so a push
// into a full FIFO is accepted when the consumer is popping.
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [WIDTH-1:0] enq_bits,
   output logic             deq_valid,
   input  logic             deq_ready,
   output logic [WIDTH-1:0] deq_bits,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_enq;
   logic             do_deq;

   assign full      = (count == (AW+1)'(DEPTH));
   assign deq_valid = (count != '0);
   assign enq_ready = !full || deq_ready;
   assign do_deq    = deq_valid && deq_ready;
   assign do_enq    = enq_valid && enq_ready;
   assign deq_bits  = mem[rd_ptr];

   // Storage carries no reset; the head is only meaningful while deq_valid is high.
   always_ff @(posedge clock) begin
      if (do_enq) mem[wr_ptr] <= enq_bits;
   end

   // Pointers wrap naturally at DEPTH; count is one bit wider to tell full from empty.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_enq) wr_ptr <= wr_ptr + 1'b1;
         if (do_deq) rd_ptr <= rd_ptr + 1'b1;
         case ({do_enq, do_deq})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronizes the line, centre-samples each bit with a baud
// down-counter, buffers bytes in a FIFO and keeps sticky frame/overrun flags.
//
//   state | meaning
//   IDLE  | line idle, waiting for a low level
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sample 8 data bits LSB first at bit centres
//   STOP  | sample the stop bit; push byte or flag a frame error
//   BREAK | line held low after a bad stop bit; wait for it to return high
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_rx,
   uart_receiver_if.master  deq,
   output logic             io_frame_error,
   output logic             io_overrun,
   input  logic             io_clear_errors,
   output logic             io_busy
);

   localparam int DIVISOR = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF    = DIVISOR / 2;
   localparam int CNT_W   = $clog2(DIVISOR);
   localparam int IDX_W   = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] RELOAD_BIT  = CNT_W'(DIVISOR - 1);
   localparam logic [CNT_W-1:0] RELOAD_HALF = CNT_W'(HALF - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);

   if (DIVISOR < 4) begin : g_divisor_too_small
      $error("uart_receiver: CLOCK_FREQ/BAUD_RATE must be at least 4");
   end

   if (STOP_BITS != 1) begin : g_stop_bits_unsupported
      $error("uart_receiver: only one stop bit is supported");
   end

   logic                 rx_meta;
   logic                 rx_sync;
   uart_rx_state_t       state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 stop_sample;
   logic                 push;
   logic                 frame_err_set;
   logic                 overrun_set;
   logic                 fifo_enq_ready;
   logic                 fifo_full;

   // Two-flop synchronizer; resets to the idle (high) line level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= io_rx;
         rx_sync <= rx_meta;
      end
   end

   // Frame sequencing; cnt is a down-counter whose terminal count marks a bit centre.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_sync) begin
                  state <= START;
                  cnt   <= RELOAD_HALF;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!rx_sync) begin
                  state <= DATA;
                  cnt   <= RELOAD_BIT;
                  idx   <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shift_reg[idx] <= rx_sync;
                  cnt            <= RELOAD_BIT;
                  if (idx == LAST_IDX) state <= STOP;
                  else                 idx   <= idx + 1'b1;
               end
            end
            STOP: begin
               if (cnt != '0) cnt   <= cnt - 1'b1;
               else           state <= rx_sync ? IDLE : BREAK;
            end
            BREAK: begin
               if (rx_sync) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stop_sample   = (state == STOP) && (cnt == '0);
   assign push          = stop_sample && rx_sync;
   assign frame_err_set = stop_sample && !rx_sync;
   // Dropped only when full and no same-cycle pop frees a slot.
   assign overrun_set   = push && fifo_full && !fifo_enq_ready;
   assign io_busy       = (state != IDLE);

   // Sticky error flags; a new event outranks a simultaneous clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_frame_error <= 1'b0;
         io_overrun     <= 1'b0;
      end else begin
         if (frame_err_set)        io_frame_error <= 1'b1;
         else if (io_clear_errors) io_frame_error <= 1'b0;
         if (overrun_set)          io_overrun     <= 1'b1;
         else if (io_clear_errors) io_overrun     <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .enq_valid (push),
      .enq_ready (fifo_enq_ready),
      .enq_bits  (shift_reg),
      .deq_valid (deq.io_deq_valid),
      .deq_ready (deq.io_deq_ready),
      .deq_bits  (deq.io_deq_bits),
      .full      (fifo_full)
   );

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries, power of two, >=2.
REQ-004 SHALL have port clock, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port io_rx, input, 1, serial line: idle high, 8N1, LSB first.
REQ-007 SHALL have port io_deq_valid, output, 1, a received byte is at the FIFO head.
REQ-008 SHALL have port io_deq_ready, input, 1, consumer accepts the head byte.
REQ-009 SHALL have port io_deq_bits, output, 8, head byte.
REQ-010 SHALL have port io_frame_error, output, 1, sticky: stop bit sampled low.
REQ-011 SHALL have port io_overrun, output, 1, sticky: byte dropped because the FIFO was full.
REQ-012 SHALL have port io_clear_errors, input, 1, one-cycle pulse clears both sticky flags.
REQ-013 SHALL have port io_busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL compute DIVISOR = CLOCK_FREQ/BAUD_RATE (integer floor) and HALF = DIVISOR/2; elaboration SHALL fail if DIVISOR < 4.
REQ-015 SHALL pass io_rx through a 2-flop synchronizer (rx_sync, reset value 1) before any use.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE: on rx_sync==0 -> START, baud counter loaded with HALF-1.
REQ-018 START: counter decrements each cycle; at 0, rx_sync==0 -> DATA (counter=DIVISOR-1, bit index=0); rx_sync==1 -> IDLE, no byte, no flag (glitch reject).
REQ-019 DATA: at counter 0, rx_sync is written into shift-register bit [index], LSB first; index 7 -> STOP, otherwise index+1; counter reloads DIVISOR-1.
REQ-020 STOP: at counter 0, rx_sync==1 -> push byte, go to IDLE; rx_sync==0 -> set io_frame_error, discard byte, go to BREAK.
REQ-021 BREAK: stay until rx_sync==1, then go to IDLE, so that a held-low line yields exactly one frame error.
REQ-022 Push latency: the byte SHALL appear on io_deq_valid/io_deq_bits the cycle after the stop-bit sample when the FIFO was empty.
REQ-023 Dequeue SHALL occur on any cycle with io_deq_valid && io_deq_ready; io_deq_bits SHALL be stable while valid is high and ready is low.
REQ-024 Push when full with no dequeue that cycle: byte dropped, io_overrun set; push when full with a simultaneous dequeue: byte accepted, no overrun.
REQ-025 Push and dequeue on an empty FIFO in the same cycle: dequeue does not happen; the byte is stored.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy is tracked with a log2(FIFO_DEPTH)+1-bit count.
REQ-027 When io_clear_errors and a new flag event occur in the same cycle, set SHALL win.
REQ-028 io_busy SHALL be combinational from the FSM state.

Reset
REQ-029 reset low SHALL immediately force: FSM=IDLE, counter=0, index=0, synchronizer flops=1, FIFO empty (io_deq_valid=0), io_frame_error=0, io_overrun=0, io_busy=0.
REQ-030 Reset asserted mid-frame SHALL abandon the frame; after release, reception SHALL resume only at the next falling edge.
REQ-031 FIFO storage contents need no reset; io_deq_bits is don't-care while io_deq_valid=0.

Structure
REQ-032 SHALL provide a shared package uart_pkg holding the FSM state enum (uart_rx_state_t) and the frame constants DATA_BITS=8 and STOP_BITS=1.
REQ-033 SHALL instantiate one sub-module, uart_rx_fifo (parameter DEPTH, WIDTH=8), with enq and deq valid/ready ports and a full output.
REQ-034 Target implementation size is 120-400 lines of RTL in total.

Verification (bench: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000 -> DIVISOR=10, HALF=5; the line is driven with the sim UART console write task at a matching bit period)
REQ-035 Send 0xA5 with ready held high -> exactly one valid beat with bits=0xA5, no flags, and io_busy low after the stop bit.
REQ-036 Drive a 3-cycle low glitch on an idle line -> no valid beat, no flags, FSM back in IDLE within 8 cycles.
REQ-037 Send 0x3C with the stop bit forced low, then hold the line low for 50 bit-times -> io_frame_error=1 once, no byte, the next frame (0x11) is received normally.
REQ-038 Hold ready low and send 0x01..0x05 -> the first 4 bytes are dequeued in order and io_overrun=1; pulse io_clear_errors -> flag cleared.
REQ-039 Hold ready high during 0x01..0x05, FIFO full, simultaneous push and pop -> all 5 bytes are delivered in order with io_overrun=0.
REQ-040 Assert reset during data bit 3 of 0x77, release, send 0x42 -> only 0x42 is delivered and all flags are 0.
